// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the two-master SDRAM arbiter
package sdram_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_OWN0 = 2'd1;
    localparam arb_state_t ST_OWN1 = 2'd2;

    typedef logic mid_t;

    localparam mid_t MID_M0 = 1'b0;
    localparam mid_t MID_M1 = 1'b1;

    localparam int unsigned DEF_MAX_PEND = 4;
    localparam int unsigned DEF_PTR_W    = $clog2(DEF_MAX_PEND);

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// rtl/sdram_arb_tag_fifo.sv - DEPTH x 1-bit master-id FIFO routing read responses in order
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_MAX_PEND,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin two-master Avalon-MM arbiter for the SDRAM slave
// Optional grant locking is built with SDRAM_ARB_LOCK_EN defined.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned BE_W     = 2,
    parameter int unsigned MAX_PEND = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [DATA_W-1:0] m1_readdata,
`ifdef SDRAM_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [BE_W-1:0]   s_byteenable,
    output logic [DATA_W-1:0] s_writedata,
    input  logic              s_waitrequest,
    input  logic              s_readdatavalid,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              rsp_err
);

    localparam int unsigned CNT_W = $clog2(MAX_PEND) + 1;

    arb_state_t state_q, state_d;
    mid_t       rr_last_q, rr_last_d;
    logic       rsp_err_q, rsp_err_d;
`ifdef SDRAM_ARB_LOCK_EN
    logic       lock_q, lock_d;
    logic       lock_x;
`endif

    logic             req0, req1, req_own, req_oth;
    logic             owning, own;
    arb_state_t       oth_state;
    logic             accept, push, pop;
    logic             pend_full, fifo_empty;
    mid_t             fifo_head;
    logic [CNT_W-1:0] pend_cnt;

    assign req0   = m0_read | m0_write;
    assign req1   = m1_read | m1_write;
    assign owning = (state_q == ST_OWN0) | (state_q == ST_OWN1);
    assign own    = (state_q == ST_OWN1);

    assign req_own   = own ? req1 : req0;
    assign req_oth   = own ? req0 : req1;
    assign oth_state = own ? ST_OWN0 : ST_OWN1;

    assign s_address    = own ? m1_address    : m0_address;
    assign s_byteenable = own ? m1_byteenable : m0_byteenable;
    assign s_writedata  = own ? m1_writedata  : m0_writedata;
    assign s_read       = owning & (own ? m1_read : m0_read) & ~pend_full;
    assign s_write      = owning & (own ? m1_write : m0_write);

    assign accept = (s_read | s_write) & ~s_waitrequest;
    assign push   = s_read & ~s_waitrequest;
    assign pop    = s_readdatavalid & ~fifo_empty;

    assign m0_waitrequest = (state_q == ST_OWN0) ? (s_waitrequest | (m0_read & pend_full)) : 1'b1;
    assign m1_waitrequest = (state_q == ST_OWN1) ? (s_waitrequest | (m1_read & pend_full)) : 1'b1;

    // Responses are routed with no added latency by the FIFO head tag
    assign m0_readdatavalid = pop & (fifo_head == MID_M0);
    assign m1_readdatavalid = pop & (fifo_head == MID_M1);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    assign rsp_err   = rsp_err_q;
    assign rsp_err_d = rsp_err_q | (s_readdatavalid & fifo_empty);

`ifdef SDRAM_ARB_LOCK_EN
    assign lock_x = own ? m1_lock : m0_lock;
`endif

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
`ifdef SDRAM_ARB_LOCK_EN
        lock_d    = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 & req1)   state_d = rr_last_q ? ST_OWN0 : ST_OWN1;
                else if (req0)     state_d = ST_OWN0;
                else if (req1)     state_d = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (accept) begin
                    rr_last_d = own;
`ifdef SDRAM_ARB_LOCK_EN
                    lock_d = lock_x;
                    if (!lock_x && req_oth) state_d = oth_state;
`else
                    if (req_oth) state_d = oth_state;
`endif
                end else if (!req_own
`ifdef SDRAM_ARB_LOCK_EN
                             && !lock_q
`endif
                            ) begin
                    state_d = req_oth ? oth_state : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= ST_IDLE;
            rr_last_q <= MID_M1;
            rsp_err_q <= 1'b0;
`ifdef SDRAM_ARB_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            rsp_err_q <= rsp_err_d;
`ifdef SDRAM_ARB_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (push),
        .push_id (own),
        .pop     (pop),
        .head    (fifo_head),
        .count   (pend_cnt),
        .full    (pend_full),
        .empty   (fifo_empty)
    );

    a_pend_bound: assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
        pend_cnt <= CNT_W'(MAX_PEND));

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [1:0]  m0_byteenable = 2'b11, m1_byteenable = 2'b11;
    logic [15:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [15:0] m0_readdata, m1_readdata;
`ifdef SDRAM_ARB_LOCK_EN
    logic        m0_lock = 0, m1_lock = 0;
`endif
    logic [23:0] s_address;
    logic        s_read, s_write;
    logic [1:0]  s_byteenable;
    logic [15:0] s_writedata;
    logic        s_waitrequest = 0;
    logic        s_readdatavalid = 0;
    logic [15:0] s_readdata = '0;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic        slv_en = 0;
    logic        mon_en = 0;
    logic [15:0] rq[$];
    logic [15:0] exp0_base, exp1_base;
    int          rcnt0 = 0, rcnt1 = 0;

    sdram_arbiter dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m0_readdata      (m0_readdata),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
        .m1_readdata      (m1_readdata),
`ifdef SDRAM_ARB_LOCK_EN
        .m0_lock          (m0_lock),
        .m1_lock          (m1_lock),
`endif
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_byteenable     (s_byteenable),
        .s_writedata      (s_writedata),
        .s_waitrequest    (s_waitrequest),
        .s_readdatavalid  (s_readdatavalid),
        .s_readdata       (s_readdata),
        .rsp_err          (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        s_readdatavalid = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Simple slave: returns the low 16 address bits one cycle after each accepted read
    always @(negedge clk)
        if (slv_en && s_read && !s_waitrequest) rq.push_back(s_address[15:0]);

    always @(posedge clk) begin
        #1;
        if (slv_en) begin
            if (rq.size() > 0) begin
                s_readdatavalid = 1;
                s_readdata      = rq.pop_front();
            end else begin
                s_readdatavalid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && m0_readdatavalid) begin
            chk("m0_rdata_order", 32'(m0_readdata), 32'(exp0_base) + 32'(rcnt0));
            rcnt0++;
        end
        if (mon_en && m1_readdatavalid) begin
            chk("m1_rdata_order", 32'(m1_readdata), 32'(exp1_base) + 32'(rcnt1));
            rcnt1++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n0, n1, gi;
        logic g0, g1;

        // reset values
        #3;
        chk("rst_m0_wait", 32'(m0_waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 1);
        chk("rst_s_read", 32'(s_read), 0);
        chk("rst_s_write", 32'(s_write), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_m0_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
        do_reset();

        // single m0 write
        m0_write = 1; m0_address = 24'h000010; m0_writedata = 16'hBEEF;
        @(negedge clk);
        chk("w_idle_s_write", 32'(s_write), 0);
        chk("w_idle_m0_wait", 32'(m0_waitrequest), 1);
        cyc();
        @(negedge clk);
        chk("w_s_write", 32'(s_write), 1);
        chk("w_s_address", 32'(s_address), 32'h10);
        chk("w_s_wdata", 32'(s_writedata), 32'hBEEF);
        chk("w_m0_wait", 32'(m0_waitrequest), 0);
        chk("w_m1_wait", 32'(m1_waitrequest), 1);
        chk("w_s_read", 32'(s_read), 0);
        cyc();
        m0_write = 0;
        @(negedge clk);
        chk("w_done_s_write", 32'(s_write), 0);

        // continuous reads from both masters: grants alternate starting with m0
        do_reset();
        slv_en = 1; mon_en = 1; rcnt0 = 0; rcnt1 = 0;
        exp0_base = 16'h0100; exp1_base = 16'h0200;
        m0_address = 24'h000100; m1_address = 24'h000200;
        m0_read = 1; m1_read = 1;
        n0 = 0; n1 = 0; gi = 0;
        for (int c = 0; c < 20 && (n0 < 3 || n1 < 3); c++) begin
            @(negedge clk);
            g0 = m0_read & ~m0_waitrequest;
            g1 = m1_read & ~m1_waitrequest;
            if (g0 | g1) begin
                chk("rr_grant_seq", 32'(g1), 32'(gi % 2));
                gi++;
            end
            cyc();
            if (g0) begin n0++; m0_address++; if (n0 == 3) m0_read = 0; end
            if (g1) begin n1++; m1_address++; if (n1 == 3) m1_read = 0; end
        end
        chk("rr_grant_total", 32'(gi), 6);
        repeat (6) cyc();
        chk("rr_m0_rdv_cnt", 32'(rcnt0), 3);
        chk("rr_m1_rdv_cnt", 32'(rcnt1), 3);
        chk("rr_rsp_err", 32'(rsp_err), 0);
        slv_en = 0; mon_en = 0; s_readdatavalid = 0;

        // m1 fills the tag FIFO, fifth read held until a response frees a slot
        do_reset();
        m1_address = 24'h000300; m1_read = 1; n1 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            g1 = m1_read & ~m1_waitrequest;
            cyc();
            if (g1) begin n1++; m1_address++; end
        end
        chk("bp_accepts", 32'(n1), 4);
        @(negedge clk);
        chk("bp_held_wait", 32'(m1_waitrequest), 1);
        cyc();
        s_readdatavalid = 1; s_readdata = 16'h0300;
        @(negedge clk);
        chk("bp_rdv_m1", 32'(m1_readdatavalid), 1);
        chk("bp_rdv_m0", 32'(m0_readdatavalid), 0);
        chk("bp_rdata", 32'(m1_readdata), 32'h0300);
        chk("bp_wait_pop_cyc", 32'(m1_waitrequest), 1);
        cyc();
        s_readdatavalid = 0;
        @(negedge clk);
        chk("bp_fifth_accept", 32'(m1_waitrequest), 0);
        cyc();
        m1_read = 0; s_readdatavalid = 1;
        @(negedge clk);
        chk("pop1_m1", 32'(m1_readdatavalid), 1);
        cyc();
        @(negedge clk);
        chk("pop2_m1", 32'(m1_readdatavalid), 1);
        cyc();
        s_readdatavalid = 0; m0_read = 1; m0_address = 24'h000400;
        @(negedge clk);
        chk("pp_idle_m0_wait", 32'(m0_waitrequest), 1);
        cyc();
        s_readdatavalid = 1;
        @(negedge clk);
        chk("pp_m0_accept", 32'(m0_waitrequest), 0);
        chk("pp_s_read", 32'(s_read), 1);
        chk("pp_pop_m1", 32'(m1_readdatavalid), 1);
        cyc();
        m0_read = 0;
        @(negedge clk);
        chk("pp_next_m1", 32'(m1_readdatavalid), 1);
        chk("pp_next_not_m0", 32'(m0_readdatavalid), 0);
        cyc();
        @(negedge clk);
        chk("pp_last_m0", 32'(m0_readdatavalid), 1);
        chk("pp_last_not_m1", 32'(m1_readdatavalid), 0);
        chk("pp_no_err_yet", 32'(rsp_err), 0);
        cyc();
        @(negedge clk);
        chk("empty_no_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
        cyc();
        s_readdatavalid = 0;
        @(negedge clk);
        chk("empty_rsp_err", 32'(rsp_err), 1);
        repeat (3) cyc();
        chk("rsp_err_sticky", 32'(rsp_err), 1);

        // asynchronous reset mid-transfer
        m0_read = 1; m0_address = 24'h000500;
        repeat (2) cyc();
        @(negedge clk);
        chk("ar_owned", 32'(m0_waitrequest), 0);
        #2;
        rst_n = 0; s_readdatavalid = 1;
        #1;
        chk("ar_m0_wait", 32'(m0_waitrequest), 1);
        chk("ar_s_read", 32'(s_read), 0);
        chk("ar_rsp_err", 32'(rsp_err), 0);
        chk("ar_no_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
        m0_read = 0; s_readdatavalid = 0;
        cyc();
        rst_n = 1;

`ifdef SDRAM_ARB_LOCK_EN
        // m0 holds the grant for three writes while m1 waits
        begin
            logic exp_seq [0:3];
            exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 1;
            do_reset();
            m0_write = 1; m0_lock = 1; m1_write = 1;
            n0 = 0; n1 = 0; gi = 0;
            for (int c = 0; c < 20 && (n0 < 3 || n1 < 1); c++) begin
                @(negedge clk);
                g0 = m0_write & ~m0_waitrequest;
                g1 = m1_write & ~m1_waitrequest;
                if ((g0 | g1) && gi < 4) begin
                    chk("lock_grant_seq", 32'(g1), 32'(exp_seq[gi]));
                    gi++;
                end
                cyc();
                if (g0) begin
                    n0++; m0_address++;
                    m0_lock = (n0 < 2);
                    if (n0 == 3) m0_write = 0;
                end
                if (g1) begin n1++; m1_write = 0; end
            end
            chk("lock_grant_total", 32'(gi), 4);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
